// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment scan display.
//   - Glyph constants, a..g active-low (bit 6 = a ... bit 0 = g).
//   - hex_to_seg(): converts a nibble to its glyph.
//   - num_pages(): returns the number of display pages needed for a word.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0000100;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b1100000;
  localparam logic [6:0] SEG_C    = 7'b0110001;
  localparam logic [6:0] SEG_D    = 7'b1000010;
  localparam logic [6:0] SEG_E    = 7'b0110000;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_DASH = 7'b1111110;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

  // ceil(data_w / (4 * hex_digits))
  function automatic int unsigned num_pages(input int unsigned data_w,
                                            input int unsigned hex_digits);
    return (data_w + 4 * hex_digits - 1) / (4 * hex_digits);
  endfunction

endpackage

// File: rtl/seg7_debounce.sv
// seg7_debounce: push-button conditioner.
//   CLK        in  system clock (rising edge)
//   RST_N      in  synchronous active-low reset
//   raw_in     in  raw asynchronous button level
//   level_out  out accepted (debounced) level
//   rise_pulse out one-cycle pulse, high in the cycle the accepted level goes 0->1
module seg7_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic raw_in,
  output logic level_out,
  output logic rise_pulse
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q, level_q;
  logic [CntW-1:0] cnt_q;
  logic            change, accept;

  // sync2_q is about to change at this edge; restarting here aligns the count with the new level.
  assign change     = sync1_q ^ sync2_q;
  assign accept     = !change && (cnt_q == CntLast);
  assign rise_pulse = accept && sync2_q && !level_q;
  assign level_out  = level_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
      if (change) begin
        cnt_q <= '0;
      end else if (cnt_q != CntLast) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (accept) begin
        level_q <= sync2_q;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: time-multiplexed hex display driver for a common-anode digit bank.
//   CLK        in  system clock (rising edge)
//   RST_N      in  synchronous active-low reset
//   data_bits  in  word to display (sampled once per frame)
//   page_btn   in  raw page-cycle push-button, active-high
//   disp_seg   out segments, active-low, [7]=dp, [6:0]=a..g
//   disp_sel   out digit enables, active-low one-hot, bit 0 = rightmost digit
//   page       out current page index
// Optional build macro SEG7_LZ_BLANK_EN: blank leading-zero hex digits within a page.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 6,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_W-1:0]     data_bits,
  input  logic                  page_btn,
  output logic [7:0]            disp_seg,
  output logic [NUM_DIGITS-1:0] disp_sel,
  output logic [3:0]            page
);

  localparam int unsigned HexDigits = NUM_DIGITS - 2;
  localparam int unsigned HexW      = 4 * HexDigits;
  localparam int unsigned NumPages  = num_pages(DATA_W, HexDigits);
  localparam int unsigned PsW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned DigW      = $clog2(NUM_DIGITS);

  localparam logic [PsW-1:0]  PsLast    = PsW'(PRESCALE - 1);
  localparam logic [DigW-1:0] LastDigit = DigW'(NUM_DIGITS - 1);
  localparam logic [DigW-1:0] SepSlot   = DigW'(HexDigits);
  localparam logic [3:0]      LastPage  = 4'(NumPages - 1);

  logic [PsW-1:0]        presc_q;
  logic [DigW-1:0]       digit_q;
  logic                  tick, tick_q;
  logic [DATA_W-1:0]     snap_q;
  logic [3:0]            dpage_q, page_q;
  logic [7:0]            seg_q;
  logic [NUM_DIGITS-1:0] sel_q;
  logic [HexW-1:0]       page_word;
  logic [3:0]            nibble;
  logic [6:0]            glyph;
  logic                  page_rise, btn_level;

  seg7_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .raw_in    (page_btn),
    .level_out (btn_level),
    .rise_pulse(page_rise)
  );

  // A press is only ever reported from a released accepted level.
  a_rise_from_low: assert property (@(posedge CLK) disable iff (!RST_N)
                                    page_rise |-> !btn_level);

  assign tick = (presc_q == PsLast);

  always_comb begin
    // Bits above DATA_W shift in as zero.
    page_word = HexW'(snap_q >> (dpage_q * HexW));
    nibble    = 4'(page_word >> {digit_q, 2'b00});
    if (digit_q == SepSlot) begin
      glyph = SEG_DASH;
    end else if (digit_q == LastDigit) begin
      glyph = hex_to_seg(dpage_q);
    end else begin
      glyph = hex_to_seg(nibble);
`ifdef SEG7_LZ_BLANK_EN
      // Blank when this and every higher nibble of the page is zero; slot 0 always shows.
      if ((digit_q != '0) && ((page_word >> {digit_q, 2'b00}) == '0)) begin
        glyph = SEG_OFF;
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      presc_q <= '0;
      digit_q <= '0;
      tick_q  <= 1'b0;
      snap_q  <= '0;
      dpage_q <= '0;
      page_q  <= '0;
      seg_q   <= 8'hFF;
      sel_q   <= '1;
    end else begin
      tick_q  <= tick;
      presc_q <= tick ? '0 : presc_q + PsW'(1);
      if (tick) begin
        if (digit_q == LastDigit) begin
          // Frame start: freeze data and page so the whole frame is consistent.
          digit_q <= '0;
          snap_q  <= data_bits;
          dpage_q <= page_q;
        end else begin
          digit_q <= digit_q + DigW'(1);
        end
      end
      if (page_rise) begin
        page_q <= (page_q == LastPage) ? '0 : page_q + 4'd1;
      end
      // Outputs load one cycle after the digit index moves, so select and segments
      // always come from the same slot state; nothing lights before the first tick.
      if (tick_q) begin
        sel_q <= ~(NUM_DIGITS'(1) << digit_q);
        seg_q <= {1'b1, glyph};
      end
    end
  end

  assign disp_seg = seg_q;
  assign disp_sel = sel_q;
  assign page     = page_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [31:0] data_bits = 32'h0;
  logic        page_btn = 1'b0;
  logic [7:0]  disp_seg;
  logic [5:0]  disp_sel;
  logic [3:0]  page;

  int n_checks = 0;
  int n_fails  = 0;

`ifdef SEG7_LZ_BLANK_EN
  localparam logic [7:0] ZeroHigh = 8'hFF;
`else
  localparam logic [7:0] ZeroHigh = 8'h81;
`endif

  always #5 CLK = ~CLK;

  seg7_scan_display #(
    .NUM_DIGITS  (6),
    .DATA_W      (32),
    .PRESCALE    (4),
    .DEBOUNCE_CYC(8)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .data_bits(data_bits),
    .page_btn (page_btn),
    .disp_seg (disp_seg),
    .disp_sel (disp_sel),
    .page     (page)
  );

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the cycle where the given digit becomes newly selected.
  task automatic goto_slot(input int idx, input string tag);
    logic [5:0] target;
    logic [5:0] prev;
    bit         found;
    found  = 1'b0;
    target = ~(6'd1 << idx);
    for (int i = 0; i < 40 && !found; i++) begin
      prev = disp_sel;
      step(1);
      if (disp_sel !== prev && disp_sel === target) found = 1'b1;
    end
    n_checks++;
    assert (found) else begin
      n_fails++;
      $error("FAIL %s: observed sel %b expected %b within 40 cycles", tag, disp_sel, target);
    end
  endtask

  initial begin
    // 1. Reset state and first lit digit
    data_bits = 32'h1234ABCD;
    step(3);
    chk("rst_sel", {2'b00, disp_sel}, 8'h3F);
    chk("rst_seg", disp_seg, 8'hFF);
    chk("rst_page", {4'h0, page}, 8'h00);
    RST_N = 1'b1;
    step(4);
    chk("dark_before_tick", {2'b00, disp_sel}, 8'h3F);
    step(1);
    chk("first_sel", {2'b00, disp_sel}, 8'h3D);
    chk("first_seg_zero_snap", disp_seg, 8'h81);

    // 2. Page 0 of 1234ABCD
    goto_slot(0, "p0_s0_sel"); chk("p0_s0", disp_seg, 8'hC2);
    goto_slot(1, "p0_s1_sel"); chk("p0_s1", disp_seg, 8'hB1);
    goto_slot(2, "p0_s2_sel"); chk("p0_s2", disp_seg, 8'hE0);
    goto_slot(3, "p0_s3_sel"); chk("p0_s3", disp_seg, 8'h88);
    goto_slot(4, "p0_sep_sel"); chk("p0_sep", disp_seg, 8'hFE);
    goto_slot(5, "p0_pg_sel"); chk("p0_pg", disp_seg, 8'h81);

    // 3. Clean press -> page 1 after 2 + 8 cycles
    page_btn = 1'b1;
    step(9);
    chk("press_early", {4'h0, page}, 8'h00);
    step(1);
    chk("press_lat", {4'h0, page}, 8'h01);
    step(10);
    page_btn = 1'b0;
    step(12);
    chk("release_noinc", {4'h0, page}, 8'h01);
    goto_slot(0, "p1_s0_sel"); chk("p1_s0", disp_seg, 8'hCC);
    goto_slot(1, "p1_s1_sel"); chk("p1_s1", disp_seg, 8'h86);
    goto_slot(2, "p1_s2_sel"); chk("p1_s2", disp_seg, 8'h92);
    goto_slot(3, "p1_s3_sel"); chk("p1_s3", disp_seg, 8'hCF);
    goto_slot(5, "p1_pg_sel"); chk("p1_pg", disp_seg, 8'hCF);
    page_btn = 1'b1;
    step(10);
    chk("press_wrap", {4'h0, page}, 8'h00);
    step(10);
    page_btn = 1'b0;
    step(12);

    // 4. Bouncy press -> exactly one increment
    page_btn = 1'b1; step(3);
    page_btn = 1'b0; step(3);
    page_btn = 1'b1; step(3);
    page_btn = 1'b0; step(3);
    chk("bounce_reject", {4'h0, page}, 8'h00);
    page_btn = 1'b1; step(20);
    page_btn = 1'b0; step(12);
    chk("bounce_one_inc", {4'h0, page}, 8'h01);

    // 5. Mid-frame data change
    page_btn = 1'b1; step(20);
    page_btn = 1'b0; step(12);
    chk("back_to_p0", {4'h0, page}, 8'h00);
    data_bits = 32'h0000FFFF;
    goto_slot(0, "ff_wait_sel");
    goto_slot(0, "ff_s0_sel"); chk("ff_s0", disp_seg, 8'hB8);
    data_bits = 32'h00000000;
    goto_slot(1, "ff_s1_sel"); chk("ff_s1_held", disp_seg, 8'hB8);
    goto_slot(3, "ff_s3_sel"); chk("ff_s3_held", disp_seg, 8'hB8);
    goto_slot(5, "ff_pg_sel"); chk("ff_pg", disp_seg, 8'h81);
    goto_slot(0, "z_s0_sel"); chk("z_s0", disp_seg, 8'h81);
    goto_slot(3, "z_s3_sel"); chk("z_s3", disp_seg, ZeroHigh);

    // 6. Leading zeros
    data_bits = 32'h00000050;
    goto_slot(0, "lz_wait_sel");
    goto_slot(0, "lz_s0_sel"); chk("lz_s0", disp_seg, 8'h81);
    goto_slot(1, "lz_s1_sel"); chk("lz_s1", disp_seg, 8'hA4);
    goto_slot(2, "lz_s2_sel"); chk("lz_s2", disp_seg, ZeroHigh);
    goto_slot(3, "lz_s3_sel"); chk("lz_s3", disp_seg, ZeroHigh);
    goto_slot(4, "lz_sep_sel"); chk("lz_sep", disp_seg, 8'hFE);

    // 7. Reset mid-frame with page 1 selected
    page_btn = 1'b1; step(20);
    page_btn = 1'b0; step(12);
    chk("pre_rst_page", {4'h0, page}, 8'h01);
    goto_slot(2, "pre_rst_sel");
    RST_N = 1'b0;
    step(1);
    chk("midrst_sel", {2'b00, disp_sel}, 8'h3F);
    chk("midrst_seg", disp_seg, 8'hFF);
    chk("midrst_page", {4'h0, page}, 8'h00);
    step(1);
    RST_N = 1'b1;
    step(4);
    chk("rerst_dark", {2'b00, disp_sel}, 8'h3F);
    step(1);
    chk("rerst_sel", {2'b00, disp_sel}, 8'h3D);
    chk("rerst_seg_zero_snap", disp_seg, 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
